gemm_ctrl: RTL and testbench

Job sequencer on the driving side of the GEMM datapath: on `start` it loads two weight rows from the weight buffer, streams `num_rows` input vectors and accumulator pairs at one row per cycle into the GEMM core, and writes the two returned results per row to the output buffer. It sits between the on-chip buffers and the GEMM core, and pulses `done` once the last result is written.

---
 rtl/gemm_pkg.sv | 18 +
 rtl/gemm_out_stage.sv | 46 ++++
 rtl/gemm_ctrl.sv | 153 +++++++++++++++
 tb/tb_gemm_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared types and latency constants for the GEMM job sequencer.
// Build option: GEMM_CTRL_RELU_EN clamps negative results to zero.
package gemm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WGT0,
    S_WGT1,
    S_STREAM,
    S_DRAIN1,
    S_DRAIN2,
    S_DONE
  } gemm_ctrl_state_t;

  localparam int GEMM_CORE_LAT = 1;
  localparam int BUF_RD_LAT    = 1;

endpackage

// File: rtl/gemm_out_stage.sv
// Write stage: row/valid register, optional ReLU, {result2, result1} pack.
// Build option: GEMM_CTRL_RELU_EN clamps negative results to zero.
module gemm_out_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    op_valid,
  input  logic [ADDR_WIDTH-1:0]   op_row,
  input  logic [ADDR_WIDTH-1:0]   out_base,
  input  logic [DATA_WIDTH-1:0]   result1,
  input  logic [DATA_WIDTH-1:0]   result2,
  output logic                    out_wr_en,
  output logic [ADDR_WIDTH-1:0]   out_wr_addr,
  output logic [2*DATA_WIDTH-1:0] out_wr_data
);

  function automatic logic [DATA_WIDTH-1:0] relu(
    input logic [DATA_WIDTH-1:0] v
  );
`ifdef GEMM_CTRL_RELU_EN
    return v[DATA_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      out_wr_en   <= 1'b0;
      out_wr_addr <= '0;
    end else begin
      out_wr_en   <= op_valid;
      out_wr_addr <= op_valid ? out_base + op_row : '0;
    end
  end

  // Core results arrive in this cycle, so the data path stays combinational.
  always_comb begin
    out_wr_data = '0;
    if (out_wr_en)
      out_wr_data = {relu(result2), relu(result1)};
  end

endmodule

// File: rtl/gemm_ctrl.sv
// GEMM job sequencer: weight load, row streaming, result write-back.
// Build option: GEMM_CTRL_RELU_EN clamps negative results to zero.
module gemm_ctrl
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int INP_CHANNEL = 16,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [ADDR_WIDTH-1:0]                  num_rows,
  input  logic [ADDR_WIDTH-1:0]                  inp_base,
  input  logic [ADDR_WIDTH-1:0]                  wgt_base,
  input  logic [ADDR_WIDTH-1:0]                  acc_base,
  input  logic [ADDR_WIDTH-1:0]                  out_base,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   wgt_rd_en,
  output logic [ADDR_WIDTH-1:0]                  wgt_rd_addr,
  input  logic [INP_CHANNEL-1:0][DATA_WIDTH-1:0] wgt_rd_data,
  output logic                                   inp_rd_en,
  output logic [ADDR_WIDTH-1:0]                  inp_rd_addr,
  input  logic [INP_CHANNEL-1:0][DATA_WIDTH-1:0] inp_rd_data,
  output logic                                   acc_rd_en,
  output logic [ADDR_WIDTH-1:0]                  acc_rd_addr,
  input  logic [2*DATA_WIDTH-1:0]                acc_rd_data,
  output logic [INP_CHANNEL-1:0][DATA_WIDTH-1:0] gemm_inp,
  output logic [INP_CHANNEL-1:0][DATA_WIDTH-1:0] gemm_wgt1,
  output logic [INP_CHANNEL-1:0][DATA_WIDTH-1:0] gemm_wgt2,
  output logic [DATA_WIDTH-1:0]                  gemm_acc1,
  output logic [DATA_WIDTH-1:0]                  gemm_acc2,
  input  logic [DATA_WIDTH-1:0]                  gemm_result1,
  input  logic [DATA_WIDTH-1:0]                  gemm_result2,
  output logic                                   out_wr_en,
  output logic [ADDR_WIDTH-1:0]                  out_wr_addr,
  output logic [2*DATA_WIDTH-1:0]                out_wr_data
);

  gemm_ctrl_state_t      state;
  logic [ADDR_WIDTH-1:0] num_q;
  logic [ADDR_WIDTH-1:0] row_q;
  logic [ADDR_WIDTH-1:0] out_base_q;
  logic [ADDR_WIDTH-1:0] op_row;
  logic                  op_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      wgt_rd_en   <= 1'b0;
      wgt_rd_addr <= '0;
      inp_rd_en   <= 1'b0;
      inp_rd_addr <= '0;
      acc_rd_en   <= 1'b0;
      acc_rd_addr <= '0;
      gemm_wgt1   <= '0;
      gemm_wgt2   <= '0;
      num_q       <= '0;
      row_q       <= '0;
      out_base_q  <= '0;
      op_valid    <= 1'b0;
      op_row      <= '0;
    end else begin
      op_valid <= inp_rd_en;
      op_row   <= row_q;
      done     <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          num_q       <= num_rows;
          out_base_q  <= out_base;
          inp_rd_addr <= inp_base;
          acc_rd_addr <= acc_base;
          row_q       <= '0;
          busy        <= 1'b1;
          if (num_rows == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state       <= S_WGT0;
            wgt_rd_en   <= 1'b1;
            wgt_rd_addr <= wgt_base;
          end
        end
        S_WGT0: begin
          state       <= S_WGT1;
          wgt_rd_addr <= wgt_rd_addr + 1'b1;
        end
        S_WGT1: begin
          state     <= S_STREAM;
          gemm_wgt1 <= wgt_rd_data;
          wgt_rd_en <= 1'b0;
          inp_rd_en <= 1'b1;
          acc_rd_en <= 1'b1;
        end
        S_STREAM: begin
          // Second weight row lands during the first streaming cycle.
          if (row_q == '0)
            gemm_wgt2 <= wgt_rd_data;
          if (row_q == num_q - 1'b1) begin
            state     <= S_DRAIN1;
            inp_rd_en <= 1'b0;
            acc_rd_en <= 1'b0;
          end else begin
            row_q       <= row_q + 1'b1;
            inp_rd_addr <= inp_rd_addr + 1'b1;
            acc_rd_addr <= acc_rd_addr + 1'b1;
          end
        end
        S_DRAIN1: state <= S_DRAIN2;
        S_DRAIN2: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    gemm_inp  = '0;
    gemm_acc1 = '0;
    gemm_acc2 = '0;
    if (op_valid) begin
      gemm_inp  = inp_rd_data;
      gemm_acc1 = acc_rd_data[DATA_WIDTH-1:0];
      gemm_acc2 = acc_rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  gemm_out_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_out (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op_row      (op_row),
    .out_base    (out_base_q),
    .result1     (gemm_result1),
    .result2     (gemm_result2),
    .out_wr_en   (out_wr_en),
    .out_wr_addr (out_wr_addr),
    .out_wr_data (out_wr_data)
  );

endmodule

// File: tb/tb_gemm_ctrl.sv
// Randomized bench for gemm_ctrl against a cycle-scheduled job model.
// Build option: GEMM_CTRL_RELU_EN changes the expected result clamp.
module tb_gemm_ctrl;

  localparam int DW = 16;
  localparam int CH = 16;
  localparam int AW = 8;
  localparam int NCYC = 8192;

  typedef logic [CH-1:0][DW-1:0] vec_t;

  typedef struct packed {
    bit          busy;
    bit          done;
    bit          wrd;
    bit          ird;
    bit          wen;
    bit [AW-1:0] wgaddr;
    bit [AW-1:0] iaddr;
    bit [AW-1:0] aaddr;
    bit [AW-1:0] waddr;
    bit [31:0]   wdata;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] num_rows, inp_base, wgt_base, acc_base, out_base;
  logic          busy, done;
  logic          wgt_rd_en, inp_rd_en, acc_rd_en;
  logic [AW-1:0] wgt_rd_addr, inp_rd_addr, acc_rd_addr;
  vec_t          wgt_rd_data, inp_rd_data;
  logic [2*DW-1:0] acc_rd_data;
  vec_t          gemm_inp, gemm_wgt1, gemm_wgt2;
  logic [DW-1:0] gemm_acc1, gemm_acc2;
  logic [DW-1:0] gemm_result1 = '0, gemm_result2 = '0;
  logic          out_wr_en;
  logic [AW-1:0] out_wr_addr;
  logic [2*DW-1:0] out_wr_data;

  vec_t        wgt_mem [256];
  vec_t        inp_mem [256];
  logic [31:0] acc_mem [256];

  exp_t ex [NCYC];
  exp_t e;
  int   cyc = 0;
  bit   chk_on = 0;
  int   vectors = 0, miscompares = 0;
  int   nwr = 0, ndone = 0;
  logic [31:0]   last_wdata;
  logic [AW-1:0] last_waddr;

  gemm_ctrl dut (
    .clk (clk), .rst (rst), .start (start), .num_rows (num_rows),
    .inp_base (inp_base), .wgt_base (wgt_base),
    .acc_base (acc_base), .out_base (out_base),
    .busy (busy), .done (done),
    .wgt_rd_en (wgt_rd_en), .wgt_rd_addr (wgt_rd_addr),
    .wgt_rd_data (wgt_rd_data),
    .inp_rd_en (inp_rd_en), .inp_rd_addr (inp_rd_addr),
    .inp_rd_data (inp_rd_data),
    .acc_rd_en (acc_rd_en), .acc_rd_addr (acc_rd_addr),
    .acc_rd_data (acc_rd_data),
    .gemm_inp (gemm_inp), .gemm_wgt1 (gemm_wgt1), .gemm_wgt2 (gemm_wgt2),
    .gemm_acc1 (gemm_acc1), .gemm_acc2 (gemm_acc2),
    .gemm_result1 (gemm_result1), .gemm_result2 (gemm_result2),
    .out_wr_en (out_wr_en), .out_wr_addr (out_wr_addr),
    .out_wr_data (out_wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] dot(input vec_t a, input vec_t b);
    logic [DW-1:0] s;
    s = '0;
    for (int i = 0; i < CH; i++) s = s + a[i] * b[i];
    return s;
  endfunction

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef GEMM_CTRL_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Environment: buffers with 1-cycle reads and a 1-cycle GEMM core.
  always @(posedge clk) begin
    if (wgt_rd_en) wgt_rd_data <= wgt_mem[wgt_rd_addr];
    if (inp_rd_en) inp_rd_data <= inp_mem[inp_rd_addr];
    if (acc_rd_en) acc_rd_data <= acc_mem[acc_rd_addr];
    gemm_result1 <= gemm_acc1 + dot(gemm_inp, gemm_wgt1);
    gemm_result2 <= gemm_acc2 + dot(gemm_inp, gemm_wgt2);
  end

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && cyc < NCYC) begin
      e = ex[cyc];
      chk("busy", 256'(busy), 256'(e.busy));
      chk("done", 256'(done), 256'(e.done));
      chk("out_wr_en", 256'(out_wr_en), 256'(e.wen));
      chk("wgt_rd_en", 256'(wgt_rd_en), 256'(e.wrd));
      chk("inp_rd_en", 256'(inp_rd_en), 256'(e.ird));
      chk("acc_rd_en", 256'(acc_rd_en), 256'(e.ird));
      if (e.wrd) chk("wgt_rd_addr", 256'(wgt_rd_addr), 256'(e.wgaddr));
      if (e.ird) begin
        chk("inp_rd_addr", 256'(inp_rd_addr), 256'(e.iaddr));
        chk("acc_rd_addr", 256'(acc_rd_addr), 256'(e.aaddr));
      end
      if (e.wen) begin
        chk("out_wr_addr", 256'(out_wr_addr), 256'(e.waddr));
        chk("out_wr_data", 256'(out_wr_data), 256'(e.wdata));
      end
      if (out_wr_en) begin
        nwr++;
        last_wdata = out_wr_data;
        last_waddr = out_wr_addr;
      end
      if (done) ndone++;
    end
  end

  initial begin
    #(10 * (NCYC - 100));
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_ports();
    num_rows = AW'($urandom);
    inp_base = AW'($urandom);
    wgt_base = AW'($urandom);
    acc_base = AW'($urandom);
    out_base = AW'($urandom);
  endtask

  // Pulses start in the current cycle (c0) and schedules what every
  // later cycle of the job must show.
  task automatic start_job(input int n, input bit [AW-1:0] ib,
                           input bit [AW-1:0] wb, input bit [AW-1:0] ab,
                           input bit [AW-1:0] ob);
    int c0;
    bit [AW-1:0] ia, aa;
    logic [DW-1:0] r1, r2;
    c0 = cyc;
    num_rows = AW'(n);
    inp_base = ib;
    wgt_base = wb;
    acc_base = ab;
    out_base = ob;
    start = 1'b1;
    if (n == 0) begin
      ex[c0+1].busy = 1;
      ex[c0+1].done = 1;
    end else begin
      for (int c = c0 + 1; c <= c0 + n + 5; c++) ex[c].busy = 1;
      ex[c0+n+5].done = 1;
      ex[c0+1].wrd = 1;
      ex[c0+1].wgaddr = wb;
      ex[c0+2].wrd = 1;
      ex[c0+2].wgaddr = wb + 8'd1;
      for (int r = 0; r < n; r++) begin
        ia = ib + AW'(r);
        aa = ab + AW'(r);
        ex[c0+3+r].ird = 1;
        ex[c0+3+r].iaddr = ia;
        ex[c0+3+r].aaddr = aa;
        r1 = acc_mem[aa][15:0] + dot(inp_mem[ia], wgt_mem[wb]);
        r2 = acc_mem[aa][31:16] + dot(inp_mem[ia], wgt_mem[wb + 8'd1]);
        ex[c0+5+r].wen = 1;
        ex[c0+5+r].waddr = ob + AW'(r);
        ex[c0+5+r].wdata = {relu(r2), relu(r1)};
      end
    end
    tick();
    start = 1'b0;
    scramble_ports();
  endtask

  int w0, d0;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    scramble_ports();
    for (int a = 0; a < 256; a++) begin
      acc_mem[a] = $urandom;
      for (int l = 0; l < CH; l++) begin
        wgt_mem[a][l] = DW'($urandom);
        inp_mem[a][l] = DW'($urandom);
      end
    end
    tick();
    tick();
    chk_on = 1;
    tick();
    chk("rst_gemm_inp", 256'(gemm_inp), 256'd0);
    chk("rst_gemm_wgt1", 256'(gemm_wgt1), 256'd0);
    chk("rst_gemm_wgt2", 256'(gemm_wgt2), 256'd0);
    chk("rst_out_wr_data", 256'(out_wr_data), 256'd0);
    chk("rst_wgt_rd_addr", 256'(wgt_rd_addr), 256'd0);
    chk("rst_out_wr_addr", 256'(out_wr_addr), 256'd0);
    rst = 1'b0;
    tick();

    // Hand-computed job: rows {53,39}.
    for (int a = 10; a < 14; a++)
      for (int l = 0; l < CH; l++) inp_mem[a][l] = 16'd1;
    for (int l = 0; l < CH; l++) begin
      wgt_mem[20][l] = 16'd2;
      wgt_mem[21][l] = 16'd3;
    end
    for (int a = 30; a < 34; a++) acc_mem[a] = {16'd5, 16'd7};
    w0 = nwr; d0 = ndone;
    start_job(4, 8'd10, 8'd20, 8'd30, 8'd40);
    repeat (10) tick();
    chk("pin_t1_data", 256'(last_wdata), 256'h0035_0027);
    chk("pin_t1_addr", 256'(last_waddr), 256'd43);
    chk("pin_t1_nwr", 256'(nwr - w0), 256'd4);
    chk("pin_t1_ndone", 256'(ndone - d0), 256'd1);

    // Empty job.
    w0 = nwr; d0 = ndone;
    start_job(0, 8'd1, 8'd2, 8'd3, 8'd4);
    repeat (6) tick();
    chk("pin_n0_nwr", 256'(nwr - w0), 256'd0);
    chk("pin_n0_ndone", 256'(ndone - d0), 256'd1);

    // Output address wrap.
    w0 = nwr;
    start_job(3, 8'd100, 8'd101, 8'd102, 8'd254);
    repeat (9) tick();
    chk("pin_wrap_addr", 256'(last_waddr), 256'd0);
    chk("pin_wrap_nwr", 256'(nwr - w0), 256'd3);

    // Start re-pulsed mid-job.
    w0 = nwr; d0 = ndone;
    start_job(4, 8'd60, 8'd70, 8'd80, 8'd90);
    repeat (3) tick();
    start = 1'b1;
    num_rows = 8'd2;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("pin_rep_nwr", 256'(nwr - w0), 256'd4);
    chk("pin_rep_ndone", 256'(ndone - d0), 256'd1);

    // Reset during the first write.
    w0 = nwr; d0 = ndone;
    start_job(4, 8'd200, 8'd210, 8'd220, 8'd230);
    repeat (4) tick();
    rst = 1'b1;
    for (int k = cyc + 1; k < cyc + 40; k++) ex[k] = '0;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("pin_rst_nwr", 256'(nwr - w0), 256'd1);
    chk("pin_rst_ndone", 256'(ndone - d0), 256'd0);
    start_job(2, 8'd5, 8'd6, 8'd7, 8'd8);
    repeat (8) tick();

    // Sign handling of results.
    for (int l = 0; l < CH; l++) inp_mem[50][l] = 16'd0;
    acc_mem[60] = 32'h0010_8001;
    start_job(1, 8'd50, 8'd11, 8'd60, 8'd12);
    repeat (7) tick();
`ifdef GEMM_CTRL_RELU_EN
    chk("pin_relu", 256'(last_wdata), 256'h0010_0000);
`else
    chk("pin_relu", 256'(last_wdata), 256'h0010_8001);
`endif

    for (int j = 0; j < 30; j++) begin
      int n;
      n = $urandom_range(0, 12);
      start_job(n, AW'($urandom), AW'($urandom), AW'($urandom),
                AW'($urandom));
      repeat (n + 5 + $urandom_range(0, 3)) tick();
    end
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
